fetch_ctrl: RTL and testbench

Fetch-stage sequencer between the instruction memory and the IF/ID pipeline register. It owns the program counter and issues one instruction-memory read per cycle under a credit limit. Returned words are buffered in a small in-order queue and presented to decode with a valid/ready handshake. It also handles redirects (branch/flush) and end-of-program detection, and raises a sticky stop flag once the front end has drained.

---
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer between instruction memory and IF/ID.
// Owns the PC, issues credit-limited 1-cycle reads, buffers words in order.
// Ports:
//   clk, rstn                   clock, synchronous active-low reset
//   redirect_valid/redirect_pc  flush front end, restart at redirect_pc
//   imem_req/imem_addr          read request and byte address (current pc)
//   imem_rdata                  read data, one cycle after imem_req
//   id_valid/id_inst/id_pc      queue head presented to decode
//   id_ready                    decode accepts the head
//   stop_out                    end of program reached and queue drained
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        stop_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } state_t;

  state_t state, state_n;

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          kill;
  logic [AW:0]   count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic resp;
  logic eop;
  logic enq;
  logic deq;

  always_comb begin
    state_n  = state;
    resp     = inflight & ~kill;
    eop      = resp & (imem_rdata == 32'h0);
    enq      = resp & (imem_rdata != 32'h0)
             & ~redirect_valid;
    // credit: buffered + outstanding must stay below DEPTH
    imem_req = rstn & (state == RUN)
             & ~redirect_valid
             & ((count + {{AW{1'b0}}, inflight}) < FULL);
    imem_addr = pc;
    id_valid  = (count != '0) & (state != HALT);
    deq       = id_valid & id_ready;
    id_inst   = id_valid ? inst_q[rptr] : 32'h0;
    id_pc     = id_valid ? pc_q[rptr] : 32'h0;
    stop_out  = (state == HALT);

    unique case (state)
      RUN:     if (eop) state_n = DRAIN;
      DRAIN:   if (count == '0) state_n = HALT;
      HALT:    state_n = HALT;
      default: state_n = RUN;
    endcase
    if (redirect_valid) state_n = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      kill        <= 1'b0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        inflight <= 1'b0;
        kill     <= 1'b0;
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
      end else begin
        inflight <= imem_req;
        // request racing the end marker must not be enqueued
        kill     <= imem_req & eop;
        if (imem_req) begin
          pc          <= pc + 32'd4;
          inflight_pc <= pc;
        end
        if (enq) wptr <= wptr + AW'(1);
        if (deq) rptr <= rptr + AW'(1);
        unique case ({enq, deq})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && enq) begin
      inst_q[wptr] <= imem_rdata;
      pc_q[wptr]   <= inflight_pc;
    end
  end

  no_overflow: assert property (
    @(posedge clk) disable iff (!rstn)
    !(enq && !deq && count == FULL)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table vectors, directed corner sequences and random
// stimulus checked against a queue-based reference of the fetch front end.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        stop_out;

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rstn(rstn),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .id_valid(id_valid),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_ready(id_ready),
    .stop_out(stop_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] eop_addr;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic [31:0] m_infl_pc;
  bit          m_infl;
  bit          m_kill;
  bit          ended;
  bit          stopped;
  bit          model_ok;
  bit          e_req;
  bit          e_valid;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == eop_addr) return 32'h0;
    return (a ^ 32'h5A5A_0000) | 32'h1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc       = RESET_PC;
    m_infl_pc = 32'h0;
    m_infl    = 1'b0;
    m_kill    = 1'b0;
    ended     = 1'b0;
    stopped   = 1'b0;
  endtask

  task automatic model_update();
    bit          resp;
    bit          eop;
    bit          ended0;
    int          n0;
    logic [31:0] d;
    if (!rstn) begin
      model_reset();
      model_ok = 1'b1;
      return;
    end
    resp   = m_infl && !m_kill;
    d      = word(m_infl_pc);
    n0     = mq.size();
    ended0 = ended;
    if (redirect_valid) begin
      mq.delete();
      mpc     = redirect_pc;
      m_infl  = 1'b0;
      m_kill  = 1'b0;
      ended   = 1'b0;
      stopped = 1'b0;
      return;
    end
    eop = resp && (d == 32'h0);
    if (e_valid && id_ready) void'(mq.pop_front());
    if (resp && d != 32'h0) mq.push_back('{inst: d, pc: m_infl_pc});
    if (eop) ended = 1'b1;
    if (ended0 && n0 == 0) stopped = 1'b1;
    m_kill = e_req && eop;
    m_infl = e_req;
    if (e_req) begin
      m_infl_pc = mpc;
      mpc       = mpc + 32'd4;
    end
  endtask

  task automatic drive(input logic r, input logic rv,
                       input logic [31:0] rp, input logic rd);
    @(negedge clk);
    rstn           = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    id_ready       = rd;
    imem_rdata     = mem_req_q ? word(mem_addr_q) : 32'hDEAD_BEEF;
    #1;
    e_req   = rstn && !ended && !stopped && !rv
            && (mq.size() + int'(m_infl) < DEPTH);
    e_valid = (mq.size() != 0) && !stopped;
    if (model_ok) begin
      chk("m_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) chk("m_addr", imem_addr, mpc);
      chk("m_valid", {31'b0, id_valid}, {31'b0, e_valid});
      if (e_valid) begin
        chk("m_pc", id_pc, mq[0].pc);
        chk("m_inst", id_inst, mq[0].inst);
      end
      chk("m_stop", {31'b0, stop_out}, {31'b0, stopped});
    end
  endtask

  task automatic tick();
    mem_req_q  = imem_req;
    mem_addr_q = imem_addr;
    model_update();
    @(posedge clk);
  endtask

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] dl[$];
  logic [31:0] first_pc;
  bit          stop_seen;
  int          hits;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
    tbl[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
    tbl[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h0};

    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    imem_rdata     = 32'h0;
    eop_addr       = 32'hFFFF_FFF0;
    mem_req_q      = 1'b0;
    mem_addr_q     = 32'h0;
    model_ok       = 1'b0;
    model_reset();

    // reset state
    drive(1'b0, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_stop", {31'b0, stop_out}, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    tick();

    // straight-line fetch, cycle-exact table
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h0, tbl[i].rdy);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, id_valid},
          {31'b0, tbl[i].valid});
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), id_inst, word(tbl[i].pc));
      end
      tick();
    end

    // backpressure
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0); tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_req", {31'b0, imem_req}, 32'h0);
    chk("bp_valid", {31'b0, id_valid}, 32'h1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1); tick();
    end

    // redirect with full queue and with a response in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0); tick();
    end
    drive(1'b1, 1'b1, 32'h100, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd1_valid", {31'b0, id_valid}, 32'h0);
    chk("rd1_req", {31'b0, imem_req}, 32'h1);
    chk("rd1_addr", imem_addr, 32'h100);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b1, 1'b1, 32'h200, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd2_valid", {31'b0, id_valid}, 32'h0);
    chk("rd2_addr", imem_addr, 32'h200);
    tick();
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (id_valid && first_pc == 32'hFFFF_FFFF) first_pc = id_pc;
      tick();
    end
    chk("rd2_first", first_pc, 32'h200);

    // end of program
    eop_addr = 32'h10;
    drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
    dl.delete();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (id_valid) dl.push_back(id_pc);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("eop_stop", {31'b0, stop_out}, 32'h1);
    chk("eop_req", {31'b0, imem_req}, 32'h0);
    chk("eop_count", 32'(dl.size()), 32'd4);
    chk("eop_last", dl[$], 32'hC);
    hits = 0;
    foreach (dl[k]) if (dl[k] == 32'h10) hits++;
    chk("eop_marker", 32'(hits), 32'd0);
    tick();

    // end marker reached under backpressure, then restart
    drive(1'b1, 1'b1, 32'h0C, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0); tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_stop", {31'b0, stop_out}, 32'h0);
    chk("hold_valid", {31'b0, id_valid}, 32'h1);
    chk("hold_pc", id_pc, 32'hC);
    tick();
    stop_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (stop_out) stop_seen = 1'b1;
      tick();
    end
    chk("hold_stopped", {31'b0, stop_seen}, 32'h1);
    drive(1'b1, 1'b1, 32'h40, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rs_stop", {31'b0, stop_out}, 32'h0);
    chk("rs_req", {31'b0, imem_req}, 32'h1);
    chk("rs_addr", imem_addr, 32'h40);
    tick();

    // reset mid-stream
    eop_addr = 32'hFFFF_FFF0;
    drive(1'b1, 1'b1, 32'h20, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1); tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mr_req_low", {31'b0, imem_req}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mr_req", {31'b0, imem_req}, 32'h1);
    chk("mr_addr", imem_addr, RESET_PC);
    chk("mr_valid", {31'b0, id_valid}, 32'h0);
    chk("mr_stop", {31'b0, stop_out}, 32'h0);
    chk("mr_inst", id_inst, 32'h0);
    chk("mr_pc", id_pc, 32'h0);
    tick();

    // randomized traffic against the reference
    eop_addr = 32'h60;
    for (int i = 0; i < 800; i++) begin
      logic        r;
      logic        rv;
      logic        rd;
      logic [31:0] rp;
      r  = ($urandom % 64) != 0;
      rv = ($urandom % 12) == 0;
      rd = ($urandom % 4) != 0;
      rp = 32'($urandom_range(0, 31)) << 2;
      drive(r, rv, rp, rd);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
